// File: rtl/dbg_pkg.sv
// Shared types for the debug controller: command codes, FSM states, status bit positions and Wishbone structs.
// The ST_DRAIN state exists only when DBG_BUS_TIMEOUT_EN is defined.
package dbg_pkg;

   typedef enum logic [7:0] {
      CMD_NOP        = 8'h00,
      CMD_RD_BURST   = 8'h01,
      CMD_WR_BURST   = 8'h02,
      CMD_HALT       = 8'h03,
      CMD_RESUME     = 8'h04,
      CMD_RST_HART   = 8'h05,
      CMD_RST_PERIPH = 8'h06,
      CMD_RST_ALL    = 8'h07,
      CMD_HALT_ALL   = 8'h08,
      CMD_RESUME_ALL = 8'h09,
      CMD_CLR_ERR    = 8'h0A
   } dbg_cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_OUT,
      ST_WR_WAIT,
      ST_WR_REQ
`ifdef DBG_BUS_TIMEOUT_EN
      , ST_DRAIN
`endif
   } dbg_state_e;

   localparam int STAT_BUSY        = 0;
   localparam int STAT_ERR_ALIGN   = 1;
   localparam int STAT_ERR_CMD     = 2;
   localparam int STAT_ERR_TIMEOUT = 3;

   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
   } wb_m2s_t;

   typedef struct packed {
      logic        ack;
      logic [31:0] dat;
   } wb_s2m_t;

endpackage

// File: rtl/dbg_ctrl_lsu.sv
// Single-word Wishbone access unit: holds a classic cycle while req is high, valid marks the ack beat.
module dbg_ctrl_lsu
   import dbg_pkg::*;
(
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        valid,
   output logic [31:0] rdata,
   output wb_m2s_t     wb_out,
   input  wb_s2m_t     wb_in
);

   always_comb begin
      wb_out.cyc = req;
      wb_out.stb = req;
      wb_out.we  = req & we;
      wb_out.sel = req ? 4'b1111 : 4'b0000;
      wb_out.adr = addr;
      wb_out.dat = wdata;
   end

   assign valid = req & wb_in.ack;
   assign rdata = wb_in.dat;

endmodule

// File: rtl/dbg_ctrl.sv
// Host-to-Wishbone debug controller: command channel, streamed bursts, per-hart halt/reset, sticky errors.
// Optional per-beat bus timeout with write drain is enabled by defining DBG_BUS_TIMEOUT_EN.
module dbg_ctrl
   import dbg_pkg::*;
#(
   parameter int NUM_HARTS   = 4,
   parameter int LEN_W       = 8,
   parameter int TIMEOUT_CYC = 1024,
   localparam int HS_W       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
   input  logic                 clk,
   input  logic                 rstn_i,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [7:0]           cmd_i,
   input  logic [HS_W-1:0]      hart_sel_i,
   input  logic [31:0]          addr_i,
   input  logic [LEN_W-1:0]     len_i,
   input  logic [31:0]          wdata_i,
   input  logic                 wdata_valid_i,
   output logic                 wdata_ready_o,
   output logic [31:0]          rdata_o,
   output logic                 rdata_valid_o,
   input  logic                 rdata_ready_i,
   output logic [3:0]           status_o,
   output logic [NUM_HARTS-1:0] halt_o,
   output logic [NUM_HARTS-1:0] core_rst_req_o,
   output logic                 periph_rst_req_o,
   output wb_m2s_t              wb_bus_o,
   input  wb_s2m_t              wb_bus_i
);

   dbg_state_e           state, state_nxt;
   logic [31:0]          addr_q, wdata_q, rdata_q;
   logic [LEN_W-1:0]     len_q;
   logic [LEN_W:0]       beat_q;
   logic                 err_align_q, err_cmd_q, err_to_q;
   logic [NUM_HARTS-1:0] halt_q, halt_nxt, core_rst_q, core_pulse;
   logic                 periph_rst_q, periph_pulse;
   logic                 load, step, rd_cap, wr_cap;
   logic                 set_align, set_cmd, clr_err;
   logic                 lsu_req, lsu_we, lsu_valid;
   logic [31:0]          lsu_rdata;
   logic                 last, hart_ok;
   logic [NUM_HARTS-1:0] hart_bit;
`ifdef DBG_BUS_TIMEOUT_EN
   logic                 to_hit, set_to;
`endif

   assign last     = (beat_q == {1'b0, len_q});
   assign hart_ok  = (32'(hart_sel_i) < NUM_HARTS);
   assign hart_bit = NUM_HARTS'(1) << hart_sel_i;

   always_comb begin
      state_nxt     = state;
      cmd_ready_o   = 1'b0;
      wdata_ready_o = 1'b0;
      rdata_valid_o = 1'b0;
      lsu_req       = 1'b0;
      lsu_we        = 1'b0;
      load          = 1'b0;
      step          = 1'b0;
      rd_cap        = 1'b0;
      wr_cap        = 1'b0;
      set_align     = 1'b0;
      set_cmd       = 1'b0;
      clr_err       = 1'b0;
      halt_nxt      = halt_q;
      core_pulse    = '0;
      periph_pulse  = 1'b0;
`ifdef DBG_BUS_TIMEOUT_EN
      set_to        = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               case (dbg_cmd_e'(cmd_i))
                  CMD_NOP: ;
                  CMD_RD_BURST, CMD_WR_BURST: begin
                     if (addr_i[1:0] != 2'b00) begin
                        set_align = 1'b1;
                     end else begin
                        load      = 1'b1;
                        state_nxt = (cmd_i == CMD_RD_BURST) ? ST_RD_REQ : ST_WR_WAIT;
                     end
                  end
                  CMD_HALT:       if (hart_ok) halt_nxt = halt_q | hart_bit;  else set_cmd = 1'b1;
                  CMD_RESUME:     if (hart_ok) halt_nxt = halt_q & ~hart_bit; else set_cmd = 1'b1;
                  CMD_RST_HART:   if (hart_ok) core_pulse = hart_bit;         else set_cmd = 1'b1;
                  CMD_RST_PERIPH: periph_pulse = 1'b1;
                  CMD_RST_ALL: begin
                     core_pulse   = '1;
                     periph_pulse = 1'b1;
                  end
                  CMD_HALT_ALL:   halt_nxt = '1;
                  CMD_RESUME_ALL: halt_nxt = '0;
                  CMD_CLR_ERR:    clr_err  = 1'b1;
                  default:        set_cmd  = 1'b1;
               endcase
            end
         end
         ST_RD_REQ: begin
            lsu_req = 1'b1;
            if (lsu_valid) begin
               rd_cap    = 1'b1;
               state_nxt = ST_RD_OUT;
            end
`ifdef DBG_BUS_TIMEOUT_EN
            else if (to_hit) begin
               set_to    = 1'b1;
               state_nxt = ST_IDLE;
            end
`endif
         end
         ST_RD_OUT: begin
            rdata_valid_o = 1'b1;
            if (rdata_ready_i) begin
               if (last) begin
                  state_nxt = ST_IDLE;
               end else begin
                  step      = 1'b1;
                  state_nxt = ST_RD_REQ;
               end
            end
         end
         ST_WR_WAIT: begin
            wdata_ready_o = 1'b1;
            if (wdata_valid_i) begin
               wr_cap    = 1'b1;
               state_nxt = ST_WR_REQ;
            end
         end
         ST_WR_REQ: begin
            lsu_req = 1'b1;
            lsu_we  = 1'b1;
            if (lsu_valid) begin
               if (last) begin
                  state_nxt = ST_IDLE;
               end else begin
                  step      = 1'b1;
                  state_nxt = ST_WR_WAIT;
               end
            end
`ifdef DBG_BUS_TIMEOUT_EN
            else if (to_hit) begin
               set_to = 1'b1;
               if (last) begin
                  state_nxt = ST_IDLE;
               end else begin
                  step      = 1'b1;
                  state_nxt = ST_DRAIN;
               end
            end
`endif
         end
`ifdef DBG_BUS_TIMEOUT_EN
         // Host still streams the rest of an aborted write; swallow it so the link stays in sync.
         ST_DRAIN: begin
            wdata_ready_o = 1'b1;
            if (wdata_valid_i) begin
               if (last) state_nxt = ST_IDLE;
               else      step      = 1'b1;
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state        <= ST_IDLE;
         beat_q       <= '0;
         rdata_q      <= '0;
         err_align_q  <= 1'b0;
         err_cmd_q    <= 1'b0;
         halt_q       <= '0;
         core_rst_q   <= '0;
         periph_rst_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         halt_q       <= halt_nxt;
         core_rst_q   <= core_pulse;
         periph_rst_q <= periph_pulse;
         if (load)      beat_q <= '0;
         else if (step) beat_q <= beat_q + (LEN_W+1)'(1);
         if (rd_cap)    rdata_q <= lsu_rdata;
         if (clr_err) begin
            err_align_q <= 1'b0;
            err_cmd_q   <= 1'b0;
         end else begin
            if (set_align) err_align_q <= 1'b1;
            if (set_cmd)   err_cmd_q   <= 1'b1;
         end
      end
   end

   // Burst address/length and the outgoing write word are pure data and need no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         addr_q <= addr_i;
         len_q  <= len_i;
      end else if (step) begin
         addr_q <= addr_q + 32'd4;
      end
      if (wr_cap) wdata_q <= wdata_i;
   end

`ifdef DBG_BUS_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
   logic [TO_W-1:0] to_q;
   logic            in_req;

   assign in_req = (state == ST_RD_REQ) || (state == ST_WR_REQ);
   assign to_hit = in_req && !lsu_valid && (to_q == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         to_q     <= '0;
         err_to_q <= 1'b0;
      end else begin
         to_q <= (in_req && !lsu_valid) ? to_q + TO_W'(1) : '0;
         if (clr_err)     err_to_q <= 1'b0;
         else if (set_to) err_to_q <= 1'b1;
      end
   end
`else
   assign err_to_q = 1'b0;
`endif

   assign rdata_o          = rdata_q;
   assign halt_o           = halt_q;
   assign core_rst_req_o   = core_rst_q;
   assign periph_rst_req_o = periph_rst_q;
   assign status_o         = {err_to_q, err_cmd_q, err_align_q, (state != ST_IDLE)};

   dbg_ctrl_lsu u_lsu (
      .req    (lsu_req),
      .we     (lsu_we),
      .addr   (addr_q),
      .wdata  (wdata_q),
      .valid  (lsu_valid),
      .rdata  (lsu_rdata),
      .wb_out (wb_bus_o),
      .wb_in  (wb_bus_i)
   );

endmodule

// File: tb/tb_dbg_ctrl.sv
// Scoreboard bench for dbg_ctrl: randomized commands against a transaction-level model with a Wishbone memory slave.
module tb_dbg_ctrl;
   import dbg_pkg::*;

   localparam int NH = 5;
   localparam int LW = 8;
   localparam int HW = $clog2(NH);
   localparam int TO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn;
   logic          cmd_valid, cmd_ready;
   logic [7:0]    cmd;
   logic [HW-1:0] hart;
   logic [31:0]   addr;
   logic [LW-1:0] len;
   logic [31:0]   wdata;
   logic          wdata_valid, wdata_ready;
   logic [31:0]   rdata;
   logic          rdata_valid, rdata_ready;
   logic [3:0]    status;
   logic [NH-1:0] halt, core_rst;
   logic          periph_rst;
   wb_m2s_t       wb_o;
   wb_s2m_t       wb_i;

   dbg_ctrl #(.NUM_HARTS(NH), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rstn_i(rstn), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_i(cmd), .hart_sel_i(hart), .addr_i(addr), .len_i(len),
      .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
      .rdata_o(rdata), .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready),
      .status_o(status), .halt_o(halt), .core_rst_req_o(core_rst),
      .periph_rst_req_o(periph_rst), .wb_bus_o(wb_o), .wb_bus_i(wb_i)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Contents of any word never written: same rule for slave and model.
   function automatic bit [31:0] fill(input bit [31:0] a);
      return a ^ 32'hA5C3_0F96;
   endfunction

   // Wishbone slave memory with random ack latency.
   bit [31:0] smem [bit [31:0]];
   bit ack_en = 1'b1;
   int swait = 0;
   initial begin
      wb_i = '0;
      forever begin
         @(posedge clk); #1;
         if (wb_i.ack) wb_i.ack = 1'b0;
         else if (rstn && wb_o.cyc && wb_o.stb && ack_en) begin
            if (swait == 0) begin
               wb_i.ack = 1'b1;
               if (wb_o.we) smem[wb_o.adr] = wb_o.dat;
               else wb_i.dat = smem.exists(wb_o.adr) ? smem[wb_o.adr] : fill(wb_o.adr);
               swait = $urandom_range(0, 3);
            end else swait--;
         end
      end
   end

   bit rd_rand = 1'b1;
   initial begin
      rdata_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         rdata_ready = rd_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
      end
   end

   // Reference model state
   typedef struct { bit we; bit [31:0] adr; bit [31:0] dat; } wb_txn_t;
   wb_txn_t   exp_wb[$];
   bit [31:0] exp_rd[$];
   bit [31:0] rmem [bit [31:0]];
   bit [NH-1:0] exp_halt = '0;
   bit e_align = 0, e_cmd = 0, e_to = 0;

   task automatic model_write(input bit [31:0] a, input bit [31:0] w[$]);
      foreach (w[i]) begin
         bit [31:0] ad;
         ad = a + 32'(4 * i);
         rmem[ad] = w[i];
         exp_wb.push_back('{1'b1, ad, w[i]});
      end
   endtask

   task automatic model_read(input bit [31:0] a, input int l);
      for (int i = 0; i <= l; i++) begin
         bit [31:0] ad, d;
         ad = a + 32'(4 * i);
         d = rmem.exists(ad) ? rmem[ad] : fill(ad);
         exp_wb.push_back('{1'b0, ad, d});
         exp_rd.push_back(d);
      end
   endtask

   task automatic model_reset();
      exp_wb.delete();
      exp_rd.delete();
      exp_halt = '0;
      e_align = 0; e_cmd = 0; e_to = 0;
   endtask

   // Monitor: bus transactions and read beats popped from the scoreboard.
   bit stalled = 1'b0;
   bit [31:0] stall_d;
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) stalled = 1'b0;
         else begin
            if (wb_o.cyc && wb_o.stb && wb_i.ack) begin
               if (exp_wb.size() == 0) begin
                  $display("FAIL wb_unexpected: bus cycle at adr %h, expected none", wb_o.adr);
                  n_chk++; n_fail++;
               end else begin
                  wb_txn_t t;
                  t = exp_wb.pop_front();
                  check("wb_adr", wb_o.adr, t.adr);
                  check("wb_we", wb_o.we, t.we);
                  if (t.we) begin
                     check("wb_wdat", wb_o.dat, t.dat);
                     check("wb_sel", wb_o.sel, 4'b1111);
                  end else check("wb_rdat", wb_i.dat, t.dat);
               end
            end
            if (rdata_valid) begin
               if (stalled) check("rdata_stable", rdata, stall_d);
               if (rdata_ready) begin
                  stalled = 1'b0;
                  if (exp_rd.size() == 0) begin
                     $display("FAIL rd_unexpected: beat %h, expected none", rdata);
                     n_chk++; n_fail++;
                  end else check("rd_beat", rdata, exp_rd.pop_front());
               end else begin
                  stalled = 1'b1;
                  stall_d = rdata;
               end
            end else stalled = 1'b0;
         end
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic issue(input bit [7:0] c, input int h, input bit [31:0] a, input int l);
      int b;
      b = 0;
      cmd_valid = 1'b1; cmd = c; hart = HW'(h); addr = a; len = LW'(l);
      @(negedge clk);
      while (!cmd_ready && b < 2000) begin @(negedge clk); b++; end
      if (!cmd_ready) fail_now("cmd_accept_timeout");
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_words(input bit [31:0] w[$]);
      int b;
      foreach (w[i]) begin
         b = 0;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         wdata = w[i]; wdata_valid = 1'b1;
         @(negedge clk);
         while (!wdata_ready && b < 2000) begin @(negedge clk); b++; end
         if (!wdata_ready) fail_now("wdata_accept_timeout");
         @(posedge clk); #1;
         wdata_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int b;
      b = 0;
      while ((status[STAT_BUSY] || exp_rd.size() != 0) && b < 5000) begin @(posedge clk); #1; b++; end
      check({name, "_idle"}, status[STAT_BUSY], 1'b0);
      check({name, "_beats_left"}, exp_rd.size(), 0);
   endtask

   task automatic check_status(input string name);
      check({name, "_status"}, status, {e_to, e_cmd, e_align, 1'b0});
   endtask

   task automatic do_write(input bit [31:0] a, input bit [31:0] w[$]);
      if (a[1:0] != 2'b00) e_align = 1;
      else model_write(a, w);
      issue(8'h02, 0, a, w.size() - 1);
      if (a[1:0] == 2'b00) send_words(w);
      wait_idle("wr");
      check_status("wr");
   endtask

   task automatic do_read(input bit [31:0] a, input int l);
      if (a[1:0] != 2'b00) e_align = 1;
      else model_read(a, l);
      issue(8'h01, 0, a, l);
      wait_idle("rd");
      check_status("rd");
   endtask

   task automatic do_ctrl(input bit [7:0] c, input int h);
      bit [NH-1:0] ep_core;
      bit ep_per, ok;
      ep_core = '0; ep_per = 0; ok = (h < NH);
      case (c)
         8'h00: ;
         8'h03: if (ok) exp_halt[h] = 1'b1; else e_cmd = 1;
         8'h04: if (ok) exp_halt[h] = 1'b0; else e_cmd = 1;
         8'h05: if (ok) ep_core[h] = 1'b1; else e_cmd = 1;
         8'h06: ep_per = 1;
         8'h07: begin ep_core = '1; ep_per = 1; end
         8'h08: exp_halt = '1;
         8'h09: exp_halt = '0;
         8'h0A: begin e_align = 0; e_cmd = 0; e_to = 0; end
         default: e_cmd = 1;
      endcase
      issue(c, h, 32'h0, 0);
      check("halt", halt, exp_halt);
      check("core_rst_pulse", core_rst, ep_core);
      check("periph_rst_pulse", periph_rst, ep_per);
      check_status("ctrl");
      @(posedge clk); #1;
      check("core_rst_end", core_rst, '0);
      check("periph_rst_end", periph_rst, 1'b0);
   endtask

   task automatic check_reset_vals(input string n);
      check({n, "_cmd_ready"}, cmd_ready, 1'b1);
      check({n, "_wdata_ready"}, wdata_ready, 1'b0);
      check({n, "_rdata_valid"}, rdata_valid, 1'b0);
      check({n, "_rdata"}, rdata, 32'h0);
      check({n, "_status"}, status, 4'h0);
      check({n, "_halt"}, halt, '0);
      check({n, "_core_rst"}, core_rst, '0);
      check({n, "_periph_rst"}, periph_rst, 1'b0);
      check({n, "_wb_cyc"}, wb_o.cyc, 1'b0);
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      model_reset();
      #1;
      check_reset_vals("reset");
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic random_ops(input int n);
      for (int k = 0; k < n; k++) begin
         int r;
         bit [31:0] a;
         bit [31:0] w[$];
         r = $urandom_range(0, 15);
         if (r == 1 || r == 2) begin
            a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (r == 1) do_read(a, $urandom_range(0, 5));
            else begin
               w.delete();
               repeat ($urandom_range(1, 6)) w.push_back($urandom);
               do_write(a, w);
            end
         end else do_ctrl((r == 15) ? 8'hC3 : 8'(r), $urandom_range(0, 7));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [31:0] w[$];
      int b;
      cmd_valid = 0; cmd = 0; hart = 0; addr = 0; len = 0; wdata = 0; wdata_valid = 0;
      rstn = 1'b1;
      @(posedge clk); #1;
      apply_reset();
      repeat (4) @(posedge clk); #1;
      check_reset_vals("idle");

      w = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
      do_write(32'h100, w);
      do_read(32'h100, 3);

      do_ctrl(8'h03, 2); check("halt_h2", halt, 5'b00100);
      do_ctrl(8'h08, 0); check("halt_all", halt, 5'b11111);
      do_ctrl(8'h04, 0); check("resume_h0", halt, 5'b11110);
      do_ctrl(8'h03, 5); check("bad_hart_err", status[STAT_ERR_CMD], 1'b1);
      check("bad_hart_halt", halt, 5'b11110);
      do_ctrl(8'h0A, 0); check("clr_err", status, 4'h0);

      e_align = 1;
      issue(8'h01, 0, 32'h102, 0);
      check("align_err", status, 4'b0010);
      @(posedge clk); #1;
      check("align_ready", cmd_ready, 1'b1);
      do_ctrl(8'h07, 0); check("rst_all_seen", halt, 5'b11110);
      do_ctrl(8'h0A, 0);

      w = '{32'h1111_2222, 32'h3333_4444};
      do_write(32'hFFFF_FFFC, w);
      do_read(32'hFFFF_FFFC, 1);
      do_read(32'h0000_8000, 255);

`ifdef DBG_BUS_TIMEOUT_EN
      ack_en = 1'b0;
      e_to = 1;
      w = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
      issue(8'h02, 0, 32'h200, 2);
      send_words(w);
      wait_idle("timeout");
      check_status("timeout");
      ack_en = 1'b1;
      do_ctrl(8'h0A, 0);
`else
      ack_en = 1'b0;
      issue(8'h01, 0, 32'h200, 0);
      b = 0;
      repeat (200) begin
         @(posedge clk); #1;
         if (!status[STAT_BUSY]) b++;
      end
      check("busy_held_cycles_idle", b, 0);
      apply_reset();
      ack_en = 1'b1;
      @(posedge clk); #1;
`endif

      rd_rand = 1'b0;
      do_ctrl(8'h08, 0);
      model_read(32'h300, 3);
      issue(8'h01, 0, 32'h300, 3);
      b = 0;
      while (!rdata_valid && b < 200) begin @(posedge clk); #1; b++; end
      check("rd_stall_reached", rdata_valid, 1'b1);
      apply_reset();
      rd_rand = 1'b1;
      repeat (3) @(posedge clk); #1;
      check_reset_vals("post_reset");

      random_ops(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
